// File: rtl/bram_pkg.sv
// Shared geometry helpers and response payload for the BRAM arbiter/controller.
package bram_pkg;

    localparam int unsigned MAX_DAT_W = 64;

    // One response: read data (zero for writes) and write flag
    typedef struct packed {
        logic [MAX_DAT_W-1:0] rdata;
        logic                 wr;
    } rsp_t;

    // Number of BRAM lines for a byte capacity of 2**size
    function automatic int unsigned f_num_lines(input int unsigned size, input int unsigned width);
        return (32'd1 << size) / (width / 8);
    endfunction

    // Address bits consumed by the byte position inside a line
    function automatic int unsigned f_line_shift(input int unsigned width);
        return $clog2(width / 8);
    endfunction

    // Address bits selecting a channel-wide lane inside a line
    function automatic int unsigned f_lane_bits(input int unsigned width, input int unsigned dat);
        return $clog2(width / dat);
    endfunction

    // Byte-offset bits below the lane select (ignored by the controller)
    function automatic int unsigned f_off_bits(input int unsigned dat);
        return $clog2(dat / 8);
    endfunction

    // Keeps vector widths legal when a field collapses to zero bits
    function automatic int unsigned f_max1(input int unsigned x);
        return (x == 0) ? 1 : x;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Per-channel fall-through response FIFO: an incoming push is visible the same cycle when empty.
module bram_rsp_fifo
    import bram_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  rsp_t i_push_data,
    input  logic i_pop,
    output logic o_valid,
    output rsp_t o_data
);

    localparam int unsigned PW = f_max1($clog2(DEPTH));
    localparam int unsigned CW = $clog2(DEPTH + 1);

    rsp_t          r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_cnt;

    logic w_empty;
    logic w_pop;
    logic w_store;
    logic w_deq;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_empty = (r_cnt == '0);
    assign o_valid = ~w_empty | i_push;
    assign o_data  = w_empty ? i_push_data : r_mem[r_rd_ptr];
    assign w_pop   = o_valid & i_pop;
    // a push that bypasses straight to a same-cycle pop is never stored
    assign w_store = i_push & ~(w_empty & w_pop);
    assign w_deq   = w_pop & ~w_empty;

    // Entry storage
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_store) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_deq)   r_rd_ptr <= f_inc(r_rd_ptr);
            r_cnt <= r_cnt + CW'(w_store) - CW'(w_deq);
        end
    end

endmodule

// File: rtl/bram_arb_ctrl.sv
// Round-robin multi-channel arbiter in front of a single-port byte-enabled BRAM.
// Optional macro BRAM_ARB_CTRL_OUTREG_EN adds a registered BRAM output stage (latency 2 instead of 1).
module bram_arb_ctrl
    import bram_pkg::*;
#(
    parameter int unsigned BRAM_SIZE    = 16,
    parameter int unsigned BRAM_WIDTH   = 128,
    parameter int unsigned IO_DAT_WIDTH = 64,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned RSP_DEPTH    = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_CH-1:0]                        req_valid,
    output logic [NUM_CH-1:0]                        req_ready,
    input  logic [NUM_CH-1:0][IO_DAT_WIDTH/8-1:0]    req_we,
    input  logic [NUM_CH-1:0][BRAM_SIZE-1:0]         req_addr,
    input  logic [NUM_CH-1:0][IO_DAT_WIDTH-1:0]      req_wdata,
    output logic [NUM_CH-1:0]                        rsp_valid,
    input  logic [NUM_CH-1:0]                        rsp_ready,
    output logic [NUM_CH-1:0][IO_DAT_WIDTH-1:0]      rsp_rdata,
    output logic [NUM_CH-1:0]                        rsp_wr
);

    localparam int unsigned NB         = IO_DAT_WIDTH / 8;
    localparam int unsigned LB         = BRAM_WIDTH / 8;
    localparam int unsigned NUM_LINES  = f_num_lines(BRAM_SIZE, BRAM_WIDTH);
    localparam int unsigned LINE_SHIFT = f_line_shift(BRAM_WIDTH);
    localparam int unsigned LINE_W     = f_max1(BRAM_SIZE - LINE_SHIFT);
    localparam int unsigned NUM_LANES  = BRAM_WIDTH / IO_DAT_WIDTH;
    localparam int unsigned LANE_W     = f_max1(f_lane_bits(BRAM_WIDTH, IO_DAT_WIDTH));
    localparam int unsigned OFF_BITS   = f_off_bits(IO_DAT_WIDTH);
    localparam int unsigned CH_W       = f_max1($clog2(NUM_CH));
    localparam int unsigned CNT_W      = $clog2(RSP_DEPTH + 1);

    logic [CH_W-1:0]              r_rr_ptr;
    logic [NUM_CH-1:0][CNT_W-1:0] r_out_cnt;
    logic [BRAM_WIDTH-1:0]        r_mem [NUM_LINES];
    logic [BRAM_WIDTH-1:0]        r_rd_line;
    logic                         r_p1_vld;
    logic [CH_W-1:0]              r_p1_ch;
    logic                         r_p1_wr;
    logic [LANE_W-1:0]            r_p1_lane;

    logic                         w_gnt_any;
    logic [CH_W-1:0]              w_gnt_ch;
    logic [NUM_CH-1:0]            w_gnt;
    logic [CH_W-1:0]              w_idx;
    logic [BRAM_SIZE-1:0]         w_addr;
    logic [NB-1:0]                w_we;
    logic [IO_DAT_WIDTH-1:0]      w_wdata;
    logic [LINE_W-1:0]            w_line;
    logic [LANE_W-1:0]            w_lane;
    logic [LB-1:0]                w_be_line;
    logic [BRAM_WIDTH-1:0]        w_wdata_line;
    logic                         w_out_vld;
    logic [CH_W-1:0]              w_out_ch;
    logic                         w_out_wr;
    logic [LANE_W-1:0]            w_out_lane;
    logic [BRAM_WIDTH-1:0]        w_out_line;
    rsp_t                         w_rsp;
    logic [NUM_CH-1:0]            w_push;
    logic [NUM_CH-1:0]            w_fifo_vld;
    logic [NUM_CH-1:0]            w_pop;
    rsp_t                         w_fifo_q [NUM_CH];

    // Round-robin pick of the first eligible channel starting at the pointer
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_ch  = '0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_idx = CH_W'((32'(r_rr_ptr) + i) % NUM_CH);
            if (!rst && !w_gnt_any && req_valid[w_idx] &&
                (r_out_cnt[w_idx] < CNT_W'(RSP_DEPTH))) begin
                w_gnt_any = 1'b1;
                w_gnt_ch  = w_idx;
            end
        end
        if (w_gnt_any) w_gnt[w_gnt_ch] = 1'b1;
    end

    assign req_ready    = w_gnt;
    assign w_addr       = req_addr[w_gnt_ch];
    assign w_we         = req_we[w_gnt_ch];
    assign w_wdata      = req_wdata[w_gnt_ch];
    assign w_line       = LINE_W'(w_addr >> LINE_SHIFT);
    assign w_lane       = LANE_W'((w_addr >> OFF_BITS) % NUM_LANES);
    assign w_be_line    = LB'(w_we) << (32'(w_lane) * NB);
    assign w_wdata_line = {NUM_LANES{w_wdata}};
    assign w_pop        = rsp_valid & rsp_ready;

    // Arbitration pointer and per-channel outstanding (in flight + buffered) counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_gnt_any) begin
                r_rr_ptr <= (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + CH_W'(1);
            end
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_out_cnt[c] <= r_out_cnt[c] + CNT_W'(w_gnt[c]) - CNT_W'(w_pop[c]);
            end
        end
    end

    // Single-port block RAM with byte write enables, read-first
    always_ff @(posedge clk) begin
        if (w_gnt_any) begin
            for (int unsigned b = 0; b < LB; b++) begin
                if (w_be_line[b]) r_mem[w_line][b*8 +: 8] <= w_wdata_line[b*8 +: 8];
            end
            r_rd_line <= r_mem[w_line];
        end
    end

    // Request tag travelling alongside the BRAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_vld  <= 1'b0;
            r_p1_ch   <= '0;
            r_p1_wr   <= 1'b0;
            r_p1_lane <= '0;
        end else begin
            r_p1_vld  <= w_gnt_any;
            r_p1_ch   <= w_gnt_ch;
            r_p1_wr   <= |w_we;
            r_p1_lane <= w_lane;
        end
    end

`ifdef BRAM_ARB_CTRL_OUTREG_EN
    logic                  r_p2_vld;
    logic [CH_W-1:0]       r_p2_ch;
    logic                  r_p2_wr;
    logic [LANE_W-1:0]     r_p2_lane;
    logic [BRAM_WIDTH-1:0] r_rd_line_q;

    // Registered BRAM output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p2_vld  <= 1'b0;
            r_p2_ch   <= '0;
            r_p2_wr   <= 1'b0;
            r_p2_lane <= '0;
        end else begin
            r_p2_vld  <= r_p1_vld;
            r_p2_ch   <= r_p1_ch;
            r_p2_wr   <= r_p1_wr;
            r_p2_lane <= r_p1_lane;
        end
        r_rd_line_q <= r_rd_line;
    end

    assign w_out_vld  = r_p2_vld;
    assign w_out_ch   = r_p2_ch;
    assign w_out_wr   = r_p2_wr;
    assign w_out_lane = r_p2_lane;
    assign w_out_line = r_rd_line_q;
`else
    assign w_out_vld  = r_p1_vld;
    assign w_out_ch   = r_p1_ch;
    assign w_out_wr   = r_p1_wr;
    assign w_out_lane = r_p1_lane;
    assign w_out_line = r_rd_line;
`endif

    // Lane extraction; writes report zero data
    always_comb begin
        w_rsp    = '0;
        w_rsp.wr = w_out_wr;
        if (!w_out_wr) begin
            w_rsp.rdata = MAX_DAT_W'(w_out_line[32'(w_out_lane)*IO_DAT_WIDTH +: IO_DAT_WIDTH]);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_push[c] = w_out_vld & (w_out_ch == CH_W'(c)) & ~rst;

        bram_rsp_fifo #(
            .DEPTH (RSP_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .i_push      (w_push[c]),
            .i_push_data (w_rsp),
            .i_pop       (rsp_ready[c] & ~rst),
            .o_valid     (w_fifo_vld[c]),
            .o_data      (w_fifo_q[c])
        );

        assign rsp_valid[c] = w_fifo_vld[c] & ~rst;
        assign rsp_rdata[c] = w_fifo_q[c].rdata[IO_DAT_WIDTH-1:0];
        assign rsp_wr[c]    = w_fifo_q[c].wr;
    end

endmodule

// File: doc/bram_arb_ctrl.md
BRAM_ARB_CTRL -- requirements
Module: bram_arb_ctrl

Interface
REQ-001 Param BRAM_SIZE, default 16: log2 of BRAM capacity in bytes.
REQ-002 Param BRAM_WIDTH, default 128: BRAM line width in bits; must be an integer multiple of IO_DAT_WIDTH.
REQ-003 Param IO_DAT_WIDTH, default 64: channel data width in bits; must be 8..64.
REQ-004 Param NUM_CH, default 2: number of requester channels, 1..8.
REQ-005 Param RSP_DEPTH, default 3: per-channel response FIFO depth.
REQ-006 clk  in  1  sole clock; all logic rises on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  [NUM_CH]  request present, one bit per channel.
REQ-009 req_ready  out  [NUM_CH]  request accepted this cycle.
REQ-010 req_we  in  [NUM_CH][IO_DAT_WIDTH/8]  byte write enables; all zero means read.
REQ-011 req_addr  in  [NUM_CH][BRAM_SIZE]  byte address.
REQ-012 req_wdata  in  [NUM_CH][IO_DAT_WIDTH]  write data.
REQ-013 rsp_valid  out  [NUM_CH]  response present.
REQ-014 rsp_ready  in  [NUM_CH]  response consumed.
REQ-015 rsp_rdata  out  [NUM_CH][IO_DAT_WIDTH]  read data; zero for write responses.
REQ-016 rsp_wr  out  [NUM_CH]  response belongs to a write.

Function
REQ-017 Storage: 2**BRAM_SIZE/(BRAM_WIDTH/8) lines of BRAM_WIDTH bits, single port, inferable as block RAM.
REQ-018 Addressing: line = addr >> log2(BRAM_WIDTH/8); lane = addr[log2(BRAM_WIDTH/8)-1 : log2(IO_DAT_WIDTH/8)]; byte offset bits below the lane are ignored.
REQ-019 Writes update only the bytes of the selected lane whose req_we bit is set; all other bytes of the line are unchanged.
REQ-020 Reads return the selected lane of the line, right-justified.
REQ-021 A channel is eligible when req_valid is high and its outstanding count (in flight plus buffered) is below RSP_DEPTH.
REQ-022 Arbitration is round-robin among eligible channels, one grant per cycle; the pointer moves to granted+1 mod NUM_CH only on a grant.
REQ-023 req_ready is high only for the granted channel; the handshake is req_valid & req_ready in cycle T.
REQ-024 Every accepted request produces exactly one response on its own channel, in acceptance order.
REQ-025 Latency: rsp_valid rises no earlier than T+LAT, with LAT=1 (2 under REQ-033); exactly T+LAT when the channel FIFO is empty (fall-through).
REQ-026 Response FIFO: holds rsp_valid, rsp_rdata and rsp_wr stable until rsp_ready; pops on rsp_valid & rsp_ready.
REQ-027 Outstanding count: +1 on grant, -1 on pop, both in the same cycle gives net 0; it never exceeds RSP_DEPTH, so the FIFO never overflows.
REQ-028 A write at T is visible to any read granted at T+1 or later.
REQ-029 With RSP_DEPTH >= LAT+1 and rsp_ready held high, a lone channel sustains one request per cycle.

Reset
REQ-030 On rst: FIFOs empty, outstanding counts 0, pipeline valids 0, RR pointer 0, rsp_valid 0, req_ready 0.
REQ-031 Requests in flight at reset are dropped; no response for them appears after reset.
REQ-032 Memory contents are not reset.

Configuration
REQ-033 With macro BRAM_ARB_CTRL_OUTREG_EN defined: registered BRAM output stage, LAT=2. Without it: LAT=1 and no extra register.

Structure
REQ-034 Package bram_pkg holds the derived-width localparams/functions (line count, lane bits, offset bits) and the response struct (rdata, wr).
REQ-035 Sub-module bram_rsp_fifo: parametrised-depth fall-through FIFO, one instance per channel.

Verification
REQ-036 ch0 write addr 0x0008, we=0xFF, data 0x1122334455667788; then ch0 read 0x0008 -> rdata 0x1122334455667788, rsp_wr=0; read 0x0000 -> prior lane-0 data unchanged.
REQ-037 Partial write we=0x0F, data 0xAAAAAAAABBBBBBBB over 0x1122334455667788 at 0x0008 -> read returns 0x11223344BBBBBBBB.
REQ-038 ch0 and ch1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each gets one grant per 2 cycles.
REQ-039 ch0 rsp_ready=0, 5 back-to-back reads -> exactly RSP_DEPTH=3 accepted, req_ready[0] then stays 0; releasing rsp_ready drains them in order.
REQ-040 Assert rst one cycle after a grant -> no rsp_valid after reset; RR pointer 0; a subsequent read returns pre-reset memory contents.
REQ-041 Run single-channel streaming reads with and without BRAM_ARB_CTRL_OUTREG_EN -> first rsp_valid at T+1 and T+2 respectively; throughput 1 per cycle in both.
